// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic player: state codes, button constants and helpers.
package jogador_automatico_pkg;

  typedef enum logic [3:0] {
    OBSERVA      = 4'd0,
    PRESSIONA    = 4'd1,
    SOLTA        = 4'd2,
    ACRESCENTA_P = 4'd3,
    ACRESCENTA_S = 4'd4,
    FIM          = 4'd5,
    HOLDOFF      = 4'd6
  } estado_t;

  localparam logic [3:0] BOTAO_0      = 4'b0001;
  localparam logic [3:0] BOTAO_1      = 4'b0010;
  localparam logic [3:0] BOTAO_2      = 4'b0100;
  localparam logic [3:0] BOTAO_3      = 4'b1000;
  localparam logic [3:0] LFSR_SEMENTE = 4'b1001;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v == BOTAO_0) || (v == BOTAO_1) || (v == BOTAO_2) || (v == BOTAO_3);
  endfunction

  function automatic logic [3:0] one_hot_de(input logic [1:0] sel);
    logic [3:0] r;
    case (sel)
      2'd0:    r = BOTAO_0;
      2'd1:    r = BOTAO_1;
      2'd2:    r = BOTAO_2;
      default: r = BOTAO_3;
    endcase
    return r;
  endfunction

  // Corrupted press: rotate left, so button 3 wraps to button 0.
  function automatic logic [3:0] rotaciona(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic int unsigned maior(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jogador_automatico_temporizador.sv
// Loadable down-counter with a registered "reached zero" flag; saturates at zero.
module temporizador_jogador #(
  parameter int unsigned LARGURA = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carregar,
  input  logic               decrementar,
  input  logic [LARGURA-1:0] valor,
  output logic               fim
);

  logic [LARGURA-1:0] contador_q, contador_d;
  logic               fim_q;

  always_comb begin
    contador_d = contador_q;
    if (carregar) begin
      contador_d = valor;
    end else if (decrementar && (contador_q != '0)) begin
      contador_d = contador_q - LARGURA'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_q <= '0;
      fim_q      <= 1'b1;
    end else begin
      contador_q <= contador_d;
      fim_q      <= (contador_d == '0);
    end
  end

  assign fim = fim_q;

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: records one-hot LED items shown by the game, then replays them on botoes.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int unsigned MIN_CICLOS   = 10,
  parameter int unsigned GAP_CICLOS   = 500,
  parameter int unsigned PRESS_CICLOS = 20,
  parameter int unsigned SOLTA_CICLOS = 80,
  parameter int unsigned PROF         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       acrescentar,
  input  logic       injeta_erro,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       concluido,
  output logic       estouro,
  output logic [4:0] db_quantidade,
  output logic [3:0] db_estado
);

  localparam int unsigned AW = $clog2(PROF);
  localparam int unsigned QW = AW + 1;
  localparam int unsigned EW = $clog2(MIN_CICLOS + 3);
  localparam int unsigned TW = $clog2(maior(maior(GAP_CICLOS, PRESS_CICLOS), SOLTA_CICLOS) + 1);

  estado_t       state_q, state_d;
  logic [3:0]    botoes_q, botoes_d;
  logic          ocupado_q, ocupado_d;
  logic          concluido_q, concluido_d;
  logic          estouro_q, estouro_d;
  logic [QW-1:0] quant_q, quant_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [EW-1:0] estab_q, estab_d;
  logic [3:0]    prev_q, prev_d;
  logic [3:0]    lfsr_q, lfsr_d;
  logic          hab_q, hab_d;

  logic [3:0]    mem_q [PROF];
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wdata;

  logic          tmr_carregar, tmr_dec, tmr_fim;
  logic [TW-1:0] tmr_valor;

  logic [AW-1:0] nxt_idx;
  logic          ultimo;
  logic [3:0]    valor_press;
  logic [3:0]    valor_extra;
  logic          um_hot;
  logic [EW-1:0] corrida;

  temporizador_jogador #(.LARGURA(TW)) u_temporizador (
    .clock       (clock),
    .reset       (reset),
    .carregar    (tmr_carregar),
    .decrementar (tmr_dec),
    .valor       (tmr_valor),
    .fim         (tmr_fim)
  );

  // Next press: index 0 when leaving OBSERVA, otherwise the following stored item.
  assign nxt_idx     = (state_q == OBSERVA) ? '0 : (idx_q + AW'(1));
  assign ultimo      = ((QW'(nxt_idx) + QW'(1)) == quant_q);
  assign valor_press = (ultimo && injeta_erro) ? rotaciona(mem_q[nxt_idx]) : mem_q[nxt_idx];
  assign valor_extra = one_hot_de(lfsr_q[1:0]);

  // Length of the current run of an unchanged one-hot value, including this cycle.
  assign um_hot  = eh_one_hot(leds);
  assign corrida = !um_hot ? '0 : ((leds == prev_q) ? (estab_q + EW'(1)) : EW'(1));

  always_comb begin
    state_d      = state_q;
    botoes_d     = botoes_q;
    concluido_d  = 1'b0;
    estouro_d    = estouro_q;
    quant_d      = quant_q;
    idx_d        = idx_q;
    estab_d      = estab_q;
    prev_d       = prev_q;
    lfsr_d       = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    hab_d        = habilitar;
    tmr_carregar = 1'b0;
    tmr_dec      = 1'b0;
    tmr_valor    = '0;
    mem_we       = 1'b0;
    mem_addr     = quant_q[AW-1:0];
    mem_wdata    = leds;

    if (habilitar && !hab_q) begin
      estouro_d = 1'b0;
    end

    if (!habilitar) begin
      state_d      = OBSERVA;
      botoes_d     = '0;
      quant_d      = '0;
      idx_d        = '0;
      estab_d      = '0;
      prev_d       = '0;
      tmr_carregar = 1'b1;
    end else begin
      unique case (state_q)
        OBSERVA: begin
          botoes_d = '0;
          prev_d   = leds;
          estab_d  = (corrida > EW'(MIN_CICLOS + 1)) ? EW'(MIN_CICLOS + 1) : corrida;
          if (corrida == EW'(MIN_CICLOS)) begin
            if (quant_q == QW'(PROF)) begin
              estouro_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              quant_d = quant_q + QW'(1);
            end
          end
          // Timer doubles as the quiet counter: reloaded by any activity on leds.
          if (leds != '0) begin
            tmr_carregar = 1'b1;
            tmr_valor    = TW'(GAP_CICLOS - 1);
          end else if (tmr_fim && (quant_q != '0)) begin
            state_d      = PRESSIONA;
            idx_d        = nxt_idx;
            botoes_d     = valor_press;
            tmr_carregar = 1'b1;
            tmr_valor    = TW'(PRESS_CICLOS - 1);
          end else begin
            tmr_dec = 1'b1;
          end
        end
        PRESSIONA, ACRESCENTA_P: begin
          if (tmr_fim) begin
            state_d      = (state_q == PRESSIONA) ? SOLTA : ACRESCENTA_S;
            botoes_d     = '0;
            tmr_carregar = 1'b1;
            tmr_valor    = TW'(SOLTA_CICLOS - 1);
          end else begin
            tmr_dec = 1'b1;
          end
        end
        SOLTA: begin
          if (!tmr_fim) begin
            tmr_dec = 1'b1;
          end else if ((QW'(idx_q) + QW'(1)) < quant_q) begin
            state_d      = PRESSIONA;
            idx_d        = nxt_idx;
            botoes_d     = valor_press;
            tmr_carregar = 1'b1;
            tmr_valor    = TW'(PRESS_CICLOS - 1);
          end else if (acrescentar) begin
            state_d      = ACRESCENTA_P;
            botoes_d     = valor_extra;
            tmr_carregar = 1'b1;
            tmr_valor    = TW'(PRESS_CICLOS - 1);
            if (quant_q < QW'(PROF)) begin
              mem_we    = 1'b1;
              mem_wdata = valor_extra;
            end
          end else begin
            state_d     = FIM;
            concluido_d = 1'b1;
            quant_d     = '0;
          end
        end
        ACRESCENTA_S: begin
          if (tmr_fim) begin
            state_d     = FIM;
            concluido_d = 1'b1;
            quant_d     = '0;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        FIM: begin
          state_d      = HOLDOFF;
          tmr_carregar = 1'b1;
          tmr_valor    = TW'(GAP_CICLOS - 1);
        end
        HOLDOFF: begin
          if (tmr_fim) begin
            state_d = OBSERVA;
            prev_d  = '0;
            estab_d = '0;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: begin
          state_d  = OBSERVA;
          botoes_d = '0;
        end
      endcase
    end

    ocupado_d = (state_d != OBSERVA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OBSERVA;
      botoes_q    <= '0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      estouro_q   <= 1'b0;
      quant_q     <= '0;
      idx_q       <= '0;
      estab_q     <= '0;
      prev_q      <= '0;
      lfsr_q      <= LFSR_SEMENTE;
      hab_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      botoes_q    <= botoes_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      estouro_q   <= estouro_d;
      quant_q     <= quant_d;
      idx_q       <= idx_d;
      estab_q     <= estab_d;
      prev_q      <= prev_d;
      lfsr_q      <= lfsr_d;
      hab_q       <= hab_d;
    end
  end

  // Sequence memory; contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign botoes        = botoes_q;
  assign ocupado       = ocupado_q;
  assign concluido     = concluido_q;
  assign estouro       = estouro_q;
  assign db_quantidade = 5'(quant_q);
  assign db_estado     = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: directed scenario table, randomized displays and corner sequences.
module tb_jogador_automatico;

  localparam int MIN   = 10;
  localparam int GAP   = 500;
  localparam int PRESS = 20;
  localparam int SOLTA = 80;
  localparam int PROF  = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilitar;
  logic [3:0] leds;
  logic       acrescentar;
  logic       injeta_erro;
  logic [3:0] botoes;
  logic       ocupado;
  logic       concluido;
  logic       estouro;
  logic [4:0] db_quantidade;
  logic [3:0] db_estado;

  jogador_automatico #(
    .MIN_CICLOS(MIN), .GAP_CICLOS(GAP), .PRESS_CICLOS(PRESS),
    .SOLTA_CICLOS(SOLTA), .PROF(PROF)
  ) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .leds(leds),
    .acrescentar(acrescentar), .injeta_erro(injeta_erro), .botoes(botoes),
    .ocupado(ocupado), .concluido(concluido), .estouro(estouro),
    .db_quantidade(db_quantidade), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int ciclos;
  always @(posedge clock or posedge reset) begin
    if (reset) ciclos <= 0;
    else       ciclos <= ciclos + 1;
  end

  int checks = 0;
  int errors = 0;

  logic [3:0] seg_v[$];
  int         seg_n[$];
  logic [3:0] esp[$];
  bit         ovf_m;

  typedef struct {
    int          nseg;
    logic [31:0] v;     // nibble j = value of segment j
    logic [63:0] n;     // byte j = length of segment j
    bit          acres;
    bit          erro;
    int          nesp;
    logic [15:0] e;     // nibble j = expected press j
  } cenario_t;

  cenario_t tab[6];

  task automatic confere(input string nome, input int atual, input int req);
    checks++;
    if (atual != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, req);
    end
  endtask

  function automatic logic [3:0] lfsr_apos(input int k);
    logic [3:0] s;
    s = 4'b1001;
    for (int i = 0; i < k; i++) s = {s[2:0], s[3] ^ s[2]};
    return s;
  endfunction

  function automatic bit eh_hot(input logic [3:0] v);
    return (v == 4'd1) || (v == 4'd2) || (v == 4'd4) || (v == 4'd8);
  endfunction

  // Reference: a run of one unchanged one-hot value lasting >= MIN cycles is one item.
  task automatic modelo();
    logic [3:0] cur;
    int         run;
    esp.delete();
    ovf_m = 1'b0;
    cur   = 4'd0;
    run   = 0;
    for (int j = 0; j <= seg_v.size(); j++) begin
      if (j < seg_v.size() && seg_v[j] == cur) begin
        run += seg_n[j];
      end else begin
        if (eh_hot(cur) && run >= MIN) begin
          if (esp.size() < PROF) esp.push_back(cur);
          else                   ovf_m = 1'b1;
        end
        if (j < seg_v.size()) begin
          cur = seg_v[j];
          run = seg_n[j];
        end
      end
    end
  endtask

  task automatic aplica_display();
    for (int j = 0; j < seg_v.size(); j++) begin
      repeat (seg_n[j]) begin
        leds = seg_v[j];
        @(negedge clock);
      end
    end
    leds = 4'd0;
  endtask

  task automatic confere_replay(input string tag, input bit acres);
    int n, total, w, len, z, h;
    bit pulso;
    logic [3:0] v, s;
    n     = esp.size();
    total = n + int'(acres);
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (botoes == 4'd0 && w < GAP + 20);
    confere({tag, " latency"}, w, GAP);
    confere({tag, " quantidade"}, int'(db_quantidade), n);
    confere({tag, " estado press"}, int'(db_estado), 1);
    for (int k = 0; k < total; k++) begin
      if (k < n) begin
        v = esp[k];
      end else begin
        s = lfsr_apos(ciclos - 1);
        v = 4'(1 << s[1:0]);
      end
      confere($sformatf("%s press%0d value", tag, k), int'(botoes), int'(v));
      len = 1;
      while (len < PRESS + 10) begin
        @(negedge clock);
        if (botoes != v) break;
        len++;
      end
      confere($sformatf("%s press%0d len", tag, k), len, PRESS);
      confere($sformatf("%s release%0d value", tag, k), int'(botoes), 0);
      z = 1;
      while (z < SOLTA + 10) begin
        @(negedge clock);
        if (botoes != 4'd0 || concluido) break;
        z++;
      end
      confere($sformatf("%s release%0d len", tag, k), z, SOLTA);
    end
    confere({tag, " concluido"}, int'(concluido), 1);
    confere({tag, " quantidade fim"}, int'(db_quantidade), 0);
    h = 0;
    pulso = 1'b0;
    while (h < GAP + 20) begin
      @(negedge clock);
      h++;
      if (concluido) pulso = 1'b1;
      if (!ocupado) break;
    end
    confere({tag, " concluido pulse"}, int'(pulso), 0);
    confere({tag, " holdoff"}, h, GAP + 1);
    confere({tag, " estado idle"}, int'(db_estado), 0);
  endtask

  task automatic confere_sem_replay(input string tag);
    bit viu;
    viu = 1'b0;
    repeat (GAP + 20) begin
      @(negedge clock);
      if (ocupado || botoes != 4'd0) viu = 1'b1;
    end
    confere({tag, " no replay"}, int'(viu), 0);
    confere({tag, " quantidade"}, int'(db_quantidade), 0);
  endtask

  task automatic espera_press(input string tag);
    int w;
    w = 0;
    while (botoes == 4'd0 && w < GAP + 20) begin
      @(negedge clock);
      w++;
    end
    confere({tag, " press seen"}, int'(botoes != 4'd0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    reset = 1'b1; habilitar = 1'b1; leds = 4'd0; acrescentar = 1'b0; injeta_erro = 1'b0;

    tab[0] = '{3, 32'h201,   64'h141414,     1'b0, 1'b0, 2, 16'h21};
    tab[1] = '{2, 32'h43,    64'h051E,       1'b0, 1'b0, 0, 16'h0};
    tab[2] = '{3, 32'h201,   64'h141414,     1'b1, 1'b0, 2, 16'h21};
    tab[3] = '{3, 32'h201,   64'h141414,     1'b0, 1'b1, 2, 16'h41};
    tab[4] = '{4, 32'h4808,  64'h0B0A0309,   1'b0, 1'b0, 2, 16'h48};
    tab[5] = '{5, 32'h24621, 64'h0F0A0C0A0A, 1'b0, 1'b1, 4, 16'h4421};

    repeat (3) @(negedge clock);
    confere("reset botoes", int'(botoes), 0);
    confere("reset ocupado", int'(ocupado), 0);
    confere("reset concluido", int'(concluido), 0);
    confere("reset estouro", int'(estouro), 0);
    confere("reset quantidade", int'(db_quantidade), 0);
    confere("reset estado", int'(db_estado), 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      seg_v.delete(); seg_n.delete(); esp.delete();
      for (int j = 0; j < tab[i].nseg; j++) begin
        seg_v.push_back(tab[i].v[4*j +: 4]);
        seg_n.push_back(int'(tab[i].n[8*j +: 8]));
      end
      for (int j = 0; j < tab[i].nesp; j++) esp.push_back(tab[i].e[4*j +: 4]);
      acrescentar = tab[i].acres;
      injeta_erro = tab[i].erro;
      aplica_display();
      if (tab[i].nesp > 0) confere_replay($sformatf("tab%0d", i), tab[i].acres);
      else                 confere_sem_replay($sformatf("tab%0d", i));
    end

    for (int r = 0; r < 6; r++) begin
      int ns;
      seg_v.delete(); seg_n.delete();
      ns = $urandom_range(2, 7);
      for (int j = 0; j < ns; j++) begin
        case ($urandom_range(0, 3))
          0: v = (j == ns - 1) ? 4'd2 : 4'd0;
          1: begin
            do v = 4'($urandom_range(1, 15)); while (eh_hot(v));
          end
          default: v = 4'(1 << $urandom_range(0, 3));
        endcase
        seg_v.push_back(v);
        seg_n.push_back($urandom_range(1, 25));
      end
      modelo();
      acrescentar = 1'($urandom_range(0, 1));
      injeta_erro = 1'($urandom_range(0, 1));
      if (injeta_erro && esp.size() > 0) esp[esp.size()-1] = {esp[esp.size()-1][2:0], esp[esp.size()-1][3]};
      aplica_display();
      if (esp.size() > 0) confere_replay($sformatf("rnd%0d", r), acrescentar);
      else                confere_sem_replay($sformatf("rnd%0d", r));
    end
    acrescentar = 1'b0; injeta_erro = 1'b0;

    confere("estouro before full", int'(estouro), 0);
    seg_v.delete(); seg_n.delete();
    for (int j = 0; j < 17; j++) begin
      seg_v.push_back((j % 2 == 0) ? 4'd1 : 4'd2);
      seg_n.push_back(12);
    end
    modelo();
    confere("model full count", esp.size(), PROF);
    aplica_display();
    confere("estouro set", int'(estouro), 1);
    confere_replay("full", 1'b0);
    confere("estouro sticky", int'(estouro), 1);
    habilitar = 1'b0;
    @(negedge clock);
    habilitar = 1'b1;
    @(negedge clock);
    confere("estouro cleared", int'(estouro), 0);

    seg_v.delete(); seg_n.delete();
    seg_v.push_back(4'd1); seg_n.push_back(15);
    seg_v.push_back(4'd2); seg_n.push_back(15);
    aplica_display();
    espera_press("abort");
    repeat (3) @(negedge clock);
    habilitar = 1'b0;
    @(negedge clock);
    confere("abort estado", int'(db_estado), 0);
    confere("abort botoes", int'(botoes), 0);
    confere("abort ocupado", int'(ocupado), 0);
    confere("abort quantidade", int'(db_quantidade), 0);
    habilitar = 1'b1;
    confere_sem_replay("abort after");

    seg_v.delete(); seg_n.delete();
    seg_v.push_back(4'd8); seg_n.push_back(15);
    aplica_display();
    espera_press("rst");
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    confere("rst botoes", int'(botoes), 0);
    confere("rst estado", int'(db_estado), 0);
    confere("rst quantidade", int'(db_quantidade), 0);
    confere("rst ocupado", int'(ocupado), 0);
    @(negedge clock);
    reset = 1'b0;
    confere_sem_replay("rst after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automatic player: the opposite end of the game's display/button interface.
- Watches the game's one-hot LED output and records each displayed item into an internal sequence memory.
- Once the display goes quiet, it replays the sequence on the game's botoes inputs with bench-like press/release timing, and can optionally append one new item.
- Sits beside circuito_exp6 in system benches and on the board as a self-play/debug driver.

Parameters:
- MIN_CICLOS, 10: consecutive stable cycles before an LED value counts as one item
- GAP_CICLOS, 500: quiet cycles (leds==0) that end display and start replay; also the post-replay holdoff
- PRESS_CICLOS, 20: cycles botoes is held per press
- SOLTA_CICLOS, 80: cycles botoes=0 after each press
- PROF, 16: sequence memory depth (power of 2)

Ports:
- clock  in  1  system clock (1 kHz on board)
- reset  in  1  asynchronous, active-high; clears all state
- habilitar  in  1  level enable; low aborts to idle
- leds  in  4  game LED output, one-hot when valid
- acrescentar  in  1  sampled at end of replay; 1 = press one extra new item
- injeta_erro  in  1  sampled at start of last replayed press; 1 = corrupt that press
- botoes  out  4  registered button drive to the game
- ocupado  out  1  high during replay/holdoff
- concluido  out  1  one-cycle pulse when replay (plus append) finishes
- estouro  out  1  sticky: capture attempted with memory full
- db_quantidade  out  5  items currently stored
- db_estado  out  4  state code

Behaviour:
- Reset (async): state OBSERVA, botoes=0, ocupado=0, concluido=0, estouro=0, quantidade=0, timers=0, LFSR=4'b1001. Memory contents are don't-care.
- habilitar=0: next edge goes to OBSERVA, botoes=0, quantidade=0, timers cleared. estouro clears on a habilitar 0->1 edge.
- One-hot check: leds in {1,2,4,8}. Any other nonzero value is a glitch; it resets the stability counter and stores nothing.
- OBSERVA:
  - Stability counter increments while leds is one-hot and unchanged from last cycle; resets on any change.
  - Item is stored on the cycle the count reaches MIN_CICLOS. It is stored once; the value must change or return to 0 before the next capture.
  - A direct change between one-hot values without a zero gap is a new item.
  - Quiet counter counts leds==0 cycles and resets on any nonzero.
  - quantidade>0 and quiet==GAP_CICLOS -> PRESSIONA with index 0.
- Full: capture when quantidade==PROF is dropped and estouro is set. Items already stored are kept.
- PRESSIONA: botoes=mem[idx] for exactly PRESS_CICLOS cycles -> SOLTA.
- SOLTA: botoes=0 for SOLTA_CICLOS cycles. Then idx+1 < quantidade -> PRESSIONA; otherwise sample acrescentar: 1 -> ACRESCENTA, 0 -> FIM.
- Erro: if injeta_erro=1 on entry to the last stored press, botoes = mem[idx] rotated left by 1 (8 -> 1).
- ACRESCENTA:
  - Press, then release, with the same timing as a normal press.
  - Value = one-hot of LFSR[1:0] (x^4+x^3+1, advanced every cycle).
  - The value is also written to mem[quantidade] if space remains.
- FIM:
  - concluido=1 for one cycle.
  - quantidade cleared.
  - HOLDOFF for GAP_CICLOS cycles, ignoring leds (the game echoes presses on leds), then OBSERVA.
- ocupado=1 in PRESSIONA, SOLTA, ACRESCENTA, FIM and HOLDOFF.
- leds are ignored throughout replay.
- botoes changes only on clock edges; there are no combinational paths from inputs to botoes.
- Reset mid-press forces botoes=0 immediately.

Decomposition:
- Shared package: state encodings (OBSERVA=0, PRESSIONA=1, SOLTA=2, ACRESCENTA_P=3, ACRESCENTA_S=4, FIM=5, HOLDOFF=6), one-hot button constants, LFSR seed.
- Natural sub-module: temporizador_jogador, a loadable down-counter with a done flag, shared by the press, release, gap and holdoff timing.
- Memory is an inline register array.

Test Plan:
- Display 0001 for 20 cycles, 0 for 20, 0010 for 20, then quiet -> after 500 quiet cycles: botoes=0001 for 20, 0 for 80, 0010 for 20, 0 for 80; concluido pulse; db_quantidade 2->0.
- leds=0011 for 30 cycles, then 0100 for 5 cycles -> nothing stored; db_quantidade=0; no replay.
- Same 2-item display with acrescentar=1 -> third press is a one-hot value matching the LFSR model.
- Same 2-item display with injeta_erro=1 -> second press is 0100 instead of 0010.
- 17 items displayed -> estouro=1; 16 presses replayed.
- reset mid-PRESSIONA -> botoes=0 within the same cycle; db_estado=0; db_quantidade=0; habilitar=0 mid-replay -> OBSERVA next edge.
